// File: rtl/key_scan_pkg.sv
// Shared definitions for the matrix-keypad scanner: code width helper,
// debounce FSM state encoding and the "no key" code.
package key_scan_pkg;

    localparam int NONE = 0;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        REPEATING
    } scan_state_t;

    // Key codes run 1..rows*cols with 0 reserved for "no key".
    function automatic int key_width(input int rows, input int cols);
        return $clog2(rows * cols + 1);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue with occupancy level; a push while full
// is only accepted when a pop frees a slot in the same cycle.
module key_event_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 5,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// Matrix-keypad scanner: one-hot column drive, synchronised row sampling,
// per-sweep single-key detection, debounce/auto-repeat FSM and event queue.
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter  int ROWS           = 5,
    parameter  int COLS           = 4,
    parameter  int SCAN_DIV       = 10000,
    parameter  int DEBOUNCE_SCANS = 4,
    parameter  int REPEAT_DELAY   = 100,
    parameter  int REPEAT_PERIOD  = 20,
    parameter  int FIFO_DEPTH     = 4,
    localparam int KW             = key_width(ROWS, COLS),
    localparam int LW             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [ROWS-1:0] i_key_in,
    output logic [COLS-1:0] o_key_out,
    input  logic            i_repeat_en,
    output logic [KW-1:0]   o_key_code,
    output logic            o_key_valid,
    input  logic            i_key_ready,
    output logic [KW-1:0]   o_held_code,
    output logic [LW-1:0]   o_fifo_level,
    output logic            o_overflow,
    input  logic            i_ovf_clr
);

    localparam int DW   = $clog2(SCAN_DIV + 1);
    localparam int CIW  = $clog2(COLS + 1);
    localparam int BW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [KW-1:0] CODE_NONE = KW'(NONE);

    logic [ROWS-1:0] key_meta;
    logic [ROWS-1:0] key_sync;
    logic [DW-1:0]   dwell;
    logic [CIW-1:0]  col;
    logic            last_dwell;
    logic            sweep_end;

    logic [1:0]      col_hits;
    logic [KW-1:0]   col_code;
    logic [1:0]      acc_hits;
    logic [KW-1:0]   acc_code;
    logic [2:0]      hit_sum;
    logic [1:0]      merged_hits;
    logic [KW-1:0]   merged_code;
    logic [KW-1:0]   sweep_result;

    scan_state_t     state, state_nxt;
    logic [KW-1:0]   cand, cand_nxt;
    logic [BW-1:0]   deb_cnt, cnt_nxt;
    logic [KW-1:0]   held, held_nxt;
    logic [RW-1:0]   rpt, rpt_nxt, rpt_sat;
    logic            restart;
    logic            accept;
    logic [KW-1:0]   accept_code;
    logic            push;
    logic [KW-1:0]   push_code;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_drop;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= i_key_in;
            key_sync <= key_meta;
        end
    end

    assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
    assign sweep_end  = last_dwell && (col == CIW'(COLS - 1));
    assign o_key_out  = COLS'(1) << col;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            dwell <= '0;
            col   <= '0;
        end else if (last_dwell) begin
            dwell <= '0;
            col   <= (col == CIW'(COLS - 1)) ? '0 : col + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // Hit counts saturate at 2: anything beyond one key is a ghost/chord and reads as no key.
    always_comb begin
        col_hits = '0;
        col_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (key_sync[r]) begin
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
                col_code = KW'(r * COLS) + KW'(col) + KW'(1);
            end
        end
    end

    assign hit_sum      = {1'b0, acc_hits} + {1'b0, col_hits};
    assign merged_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign merged_code  = (col_hits != 2'd0) ? col_code : acc_code;
    assign sweep_result = (merged_hits == 2'd1) ? merged_code : CODE_NONE;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (sweep_end) begin
            acc_hits <= '0;
            acc_code <= '0;
        end else if (last_dwell) begin
            acc_hits <= merged_hits;
            acc_code <= merged_code;
        end
    end

    assign rpt_sat = (int'(rpt) >= REPEAT_DELAY) ? rpt : rpt + 1'b1;

    // Any disagreement with the held/candidate key restarts debounce on the new result; a candidate of 0 is a pending release.
    always_comb begin
        state_nxt   = state;
        cand_nxt    = cand;
        cnt_nxt     = deb_cnt;
        held_nxt    = held;
        rpt_nxt     = rpt;
        push        = 1'b0;
        push_code   = held;
        restart     = 1'b0;
        accept      = 1'b0;
        accept_code = cand;
        if (sweep_end) begin
            unique case (state)
                IDLE: begin
                    restart = (sweep_result != CODE_NONE);
                end
                DEBOUNCE: begin
                    if (sweep_result == cand) begin
                        if (int'(deb_cnt) + 1 >= DEBOUNCE_SCANS) begin
                            accept = 1'b1;
                        end else begin
                            cnt_nxt = deb_cnt + 1'b1;
                        end
                    end else if (sweep_result == CODE_NONE && held == CODE_NONE) begin
                        state_nxt = IDLE;
                        cand_nxt  = CODE_NONE;
                        cnt_nxt   = '0;
                    end else if (sweep_result == held) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        rpt_nxt   = '0;
                    end else begin
                        restart = 1'b1;
                    end
                end
                PRESSED: begin
                    if (sweep_result != held) begin
                        restart = 1'b1;
                    end else if (int'(rpt_sat) == REPEAT_DELAY && i_repeat_en) begin
                        push      = 1'b1;
                        state_nxt = REPEATING;
                        rpt_nxt   = '0;
                    end else begin
                        rpt_nxt = rpt_sat;
                    end
                end
                REPEATING: begin
                    if (sweep_result != held) begin
                        restart = 1'b1;
                    end else if (!i_repeat_en) begin
                        state_nxt = PRESSED;
                        rpt_nxt   = '0;
                    end else if (int'(rpt) + 1 >= REPEAT_PERIOD) begin
                        push    = 1'b1;
                        rpt_nxt = '0;
                    end else begin
                        rpt_nxt = rpt + 1'b1;
                    end
                end
            endcase
        end
        if (restart) begin
            accept_code = sweep_result;
            rpt_nxt     = '0;
            if (DEBOUNCE_SCANS <= 1) begin
                accept = 1'b1;
            end else begin
                state_nxt = DEBOUNCE;
                cand_nxt  = sweep_result;
                cnt_nxt   = BW'(1);
            end
        end
        if (accept) begin
            held_nxt = accept_code;
            cand_nxt = accept_code;
            cnt_nxt  = '0;
            rpt_nxt  = '0;
            if (accept_code != CODE_NONE) begin
                push      = 1'b1;
                push_code = accept_code;
                state_nxt = PRESSED;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= IDLE;
            cand    <= '0;
            deb_cnt <= '0;
            held    <= '0;
            rpt     <= '0;
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            deb_cnt <= cnt_nxt;
            held    <= held_nxt;
            rpt     <= rpt_nxt;
        end
    end

    assign o_held_code = held;
    assign o_key_valid = !fifo_empty;
    assign fifo_drop   = push && fifo_full && !(o_key_valid && i_key_ready);

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KW)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rstn),
        .push      (push),
        .push_data (push_code),
        .pop       (i_key_ready),
        .head      (o_key_code),
        .level     (o_fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_overflow <= 1'b0;
        end else if (fifo_drop) begin
            o_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with a 5x4 keypad model driven from the column outputs.
module tb_key_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] key_in;
    logic [3:0] key_out;
    logic       repeat_en;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [4:0] held_code;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;

    int key_a;
    int key_b;
    int total;
    int bad;
    int pops;
    int last_pop;
    int base;
    logic [3:0] walk [4];

    key_scan_ctrl #(
        .ROWS           (5),
        .COLS           (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .REPEAT_DELAY   (5),
        .REPEAT_PERIOD  (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_key_in     (key_in),
        .o_key_out    (key_out),
        .i_repeat_en  (repeat_en),
        .o_key_code   (key_code),
        .o_key_valid  (key_valid),
        .i_key_ready  (key_ready),
        .o_held_code  (held_code),
        .o_fifo_level (fifo_level),
        .o_overflow   (overflow),
        .i_ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its row to its column while that column is driven.
    always_comb begin
        key_in = '0;
        for (int c = 0; c < 4; c++) begin
            if (key_out[c]) begin
                if (key_a != 0 && (key_a - 1) % 4 == c) key_in[(key_a - 1) / 4] = 1'b1;
                if (key_b != 0 && (key_b - 1) % 4 == c) key_in[(key_b - 1) / 4] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid && key_ready) begin
            pops     <= pops + 1;
            last_pop <= int'(key_code);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int a, input int b, input int nclk);
        key_a = a;
        key_b = b;
        repeat (nclk) @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; pops = 0; last_pop = 0;
        key_a = 0; key_b = 0;
        rst_n = 1'b0; repeat_en = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;
        walk[0] = 4'd2; walk[1] = 4'd4; walk[2] = 4'd8; walk[3] = 4'd1;

        repeat (3) @(negedge clk);
        checkOutput("rst_col", key_out, 1);
        checkOutput("rst_valid", key_valid, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_held", held_code, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_code", key_code, 0);

        rst_n = 1'b1;
        checkOutput("walk0", key_out, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 4);
            checkOutput("walk", key_out, walk[i]);
        end

        key_ready = 1'b1;
        base = pops;
        applyStimulus(10, 0, 47);
        checkOutput("press_pre_valid", key_valid, 0);
        applyStimulus(10, 0, 1);
        checkOutput("press_valid", key_valid, 1);
        checkOutput("press_code", key_code, 10);
        checkOutput("press_held", held_code, 10);
        checkOutput("press_level", fifo_level, 1);
        applyStimulus(10, 0, 48);
        checkOutput("press_events", pops - base, 1);
        checkOutput("press_popcode", last_pop, 10);
        checkOutput("press_drained", key_valid, 0);
        applyStimulus(0, 0, 32);
        checkOutput("release_hold", held_code, 10);
        applyStimulus(0, 0, 16);
        checkOutput("release_held", held_code, 0);
        checkOutput("release_noevent", pops - base, 1);

        base = pops;
        applyStimulus(10, 0, 32);
        applyStimulus(0, 0, 16);
        applyStimulus(10, 0, 32);
        checkOutput("bounce_none", pops - base, 0);
        checkOutput("bounce_held0", held_code, 0);
        applyStimulus(10, 0, 16);
        checkOutput("bounce_valid", key_valid, 1);
        checkOutput("bounce_code", key_code, 10);
        applyStimulus(10, 0, 16);
        checkOutput("bounce_events", pops - base, 1);
        applyStimulus(0, 0, 48);
        checkOutput("bounce_release", held_code, 0);

        base = pops;
        applyStimulus(7, 6, 64);
        checkOutput("ghost_held", held_code, 0);
        checkOutput("ghost_valid", key_valid, 0);
        checkOutput("ghost_events", pops - base, 0);
        applyStimulus(0, 0, 16);

        repeat_en = 1'b1;
        base = pops;
        applyStimulus(7, 0, 48);
        checkOutput("rpt_first_valid", key_valid, 1);
        checkOutput("rpt_first_code", key_code, 7);
        checkOutput("rpt_held", held_code, 7);
        applyStimulus(7, 0, 64);
        checkOutput("rpt_delay_events", pops - base, 1);
        checkOutput("rpt_delay_valid", key_valid, 0);
        applyStimulus(7, 0, 16);
        checkOutput("rpt_s8_valid", key_valid, 1);
        checkOutput("rpt_s8_code", key_code, 7);
        applyStimulus(7, 0, 48);
        checkOutput("rpt_s11_events", pops - base, 3);
        checkOutput("rpt_s11_level", fifo_level, 0);
        checkOutput("rpt_popcode", last_pop, 7);
        key_ready = 1'b0;
        applyStimulus(7, 0, 16);
        checkOutput("rpt_s12_level", fifo_level, 1);
        applyStimulus(7, 0, 112);
        checkOutput("full_level", fifo_level, 4);
        checkOutput("full_noovf", overflow, 0);
        applyStimulus(7, 0, 16);
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_level", fifo_level, 4);
        checkOutput("ovf_code", key_code, 7);
        ovf_clr = 1'b1;
        applyStimulus(7, 0, 1);
        ovf_clr = 1'b0;
        checkOutput("ovf_clr", overflow, 0);
        checkOutput("ovf_clr_level", fifo_level, 4);
        applyStimulus(7, 0, 30);
        key_ready = 1'b1;
        applyStimulus(7, 0, 1);
        key_ready = 1'b0;
        checkOutput("fullpp_level", fifo_level, 4);
        checkOutput("fullpp_noovf", overflow, 0);
        checkOutput("fullpp_events", pops - base, 4);

        applyStimulus(10, 0, 24);
        checkOutput("mid_held", held_code, 7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_col", key_out, 1);
        checkOutput("arst_valid", key_valid, 0);
        checkOutput("arst_level", fifo_level, 0);
        checkOutput("arst_held", held_code, 0);
        checkOutput("arst_ovf", overflow, 0);
        checkOutput("arst_code", key_code, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        key_a = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
